traffic_phase_ctrl: RTL
=======================

TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 The block SHALL have parameter T_GREEN, default 4'd9, green duration in ticks.
REQ-002 The block SHALL have parameter T_YELLOW, default 4'd3, yellow duration in ticks.
REQ-003 The block SHALL have parameter T_ALLRED, default 4'd1, all-red clearance duration in ticks.
REQ-004 The block SHALL have parameter T_WALK, default 4'd6, pedestrian walk duration in ticks.
REQ-005 The block SHALL have port sys_clk, input, 1, the single clock; all logic rising-edge.
REQ-006 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have port timer_exp, input, 1, timer-expired flag from the phase timer.
REQ-008 The block SHALL have port ped_req, input, 1, pedestrian button, level or pulse.
REQ-009 The block SHALL have port emerg, input, 1, emergency override, synchronous to sys_clk.
REQ-010 The block SHALL have port st_timer, output, 1, timer run enable.
REQ-011 The block SHALL have port repro, output, 1, timer clear.
REQ-012 The block SHALL have port time_val, output, 4, duration loaded into the timer.
REQ-013 The block SHALL have ports ns_light and ew_light, output, 3 each, one-hot {R,Y,G}: 100=red, 010=yellow, 001=green.
REQ-014 The block SHALL have port walk, output, 1, pedestrian walk lamp.
REQ-015 The block SHALL have port phase, output, 3, current state code.

Function
REQ-016 The FSM SHALL use these states and codes: NS_G=0, NS_Y=1, AR1=2, EW_G=3, EW_Y=4, AR2=5, WALK=6, EMG=7.
REQ-017 The normal sequence SHALL be NS_G->NS_Y->AR1->EW_G->EW_Y->AR2->NS_G.
REQ-018 time_val SHALL equal T_GREEN in NS_G/EW_G, T_YELLOW in NS_Y/EW_Y, T_ALLRED in AR1/AR2, T_WALK in WALK, and 0 in EMG.
REQ-019 A registered arm flag SHALL be set on every state entry and SHALL clear after one cycle.
REQ-020 repro SHALL equal arm OR (state==EMG), combinationally from registers.
REQ-021 st_timer SHALL be 1 iff arm=0 and state!=EMG.
REQ-022 timer_exp SHALL be ignored while arm=1 or state=EMG.
REQ-023 Otherwise, timer_exp=1 sampled at a sys_clk edge SHALL move the FSM to its next state at that edge, with arm=1.
REQ-024 The transition SHALL take exactly one cycle; the controller SHALL add no further latency.
REQ-025 ped_req=1 at any edge SHALL set sticky ped_pend.
REQ-026 ped_pend SHALL clear on the edge that enters WALK; if set and clear coincide, the set SHALL be dropped.
REQ-027 On expiry in AR1 or AR2 with ped_pend=1, the FSM SHALL enter WALK instead of the next green.
REQ-028 A register nxt_dir SHALL record which green follows: EW_G after AR1, NS_G after AR2.
REQ-029 WALK expiry SHALL go to the green held in nxt_dir.
REQ-030 In WALK, both ns_light and ew_light SHALL be 100 and walk SHALL be 1; walk SHALL be 0 in every other state.
REQ-031 Lights SHALL be: NS_G ns=001, ew=100; NS_Y ns=010, ew=100; EW_G ns=100, ew=001; EW_Y ns=100, ew=010; AR1/AR2/EMG both 100.
REQ-032 emerg=1 at any edge SHALL force the next state to EMG, with priority over timer_exp and ped_pend.
REQ-033 The FSM SHALL hold EMG while emerg=1.
REQ-034 On the first edge with emerg=0 in EMG, the FSM SHALL go to AR2 with arm=1, so NS_G follows after clearance.
REQ-035 ped_pend SHALL be preserved through EMG.
REQ-036 Lights, walk and phase SHALL be decoded from registered state only, with no combinational path from inputs.

Reset
REQ-037 While reset=1, regardless of sys_clk, the block SHALL hold state=AR2, arm=1, ped_pend=0, nxt_dir=NS_G.
REQ-038 Outputs during reset SHALL be repro=1, st_timer=0, time_val=T_ALLRED, ns_light=ew_light=100, walk=0, phase=5.
REQ-039 Reset asserted mid-phase SHALL abort the phase immediately; no yellow SHALL be forced.

Verification
REQ-040 Release reset with an ideal timer (timer_exp one cycle after T ticks): phase SHALL go 5,0,1,2,3,4,5,0, and each phase SHALL show one repro cycle and the matching time_val (1,9,3,1,9,3).
REQ-041 Pulse ped_req one cycle during NS_G: after NS_Y and AR1 expire, phase SHALL be 6 with walk=1 and time_val=6; after WALK expiry, phase SHALL be 3 (EW_G) and ped_pend SHALL be 0.
REQ-042 Assert emerg during EW_G: on the next edge phase SHALL be 7, lights 100/100, repro=1, st_timer=0; after deassert, phase SHALL be 5 then 0.
REQ-043 Drive timer_exp=1 in the arm cycle: state SHALL NOT change that cycle.
REQ-044 Drive timer_exp and emerg together: EMG SHALL win.
REQ-045 Assert reset asynchronously mid-NS_Y with no clock edge: outputs SHALL immediately show phase=5, lights 100/100, repro=1.

Source files
------------

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - two-direction traffic phase FSM with pedestrian walk and emergency override
// Drives an external phase timer (clear/run/duration) and decodes lamps from registered state.
module traffic_phase_ctrl #(
  parameter logic [3:0] T_GREEN  = 4'd9,
  parameter logic [3:0] T_YELLOW = 4'd3,
  parameter logic [3:0] T_ALLRED = 4'd1,
  parameter logic [3:0] T_WALK   = 4'd6
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       timer_exp,
  input  logic       ped_req,
  input  logic       emerg,
  output logic       st_timer,
  output logic       repro,
  output logic [3:0] time_val,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    AR1  = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    AR2  = 3'd5,
    WALK = 3'd6,
    EMG  = 3'd7
  } state_t;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  state_t state_q, state_d;
  logic   arm_q, arm_d;
  logic   ped_pend_q, ped_pend_d;
  logic   nxt_dir_q, nxt_dir_d;  // 0: NS_G follows the walk, 1: EW_G follows

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q    <= AR2;
      arm_q      <= 1'b1;
      ped_pend_q <= 1'b0;
      nxt_dir_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_q      <= arm_d;
      ped_pend_q <= ped_pend_d;
      nxt_dir_q  <= nxt_dir_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    arm_d      = 1'b0;
    ped_pend_d = ped_pend_q | ped_req;
    nxt_dir_d  = nxt_dir_q;
    if (emerg) begin
      state_d = EMG;
      arm_d   = (state_q != EMG);
    end else if (state_q == EMG) begin
      state_d   = AR2;
      arm_d     = 1'b1;
      nxt_dir_d = 1'b0;
    end else if (!arm_q && timer_exp) begin
      arm_d = 1'b1;
      case (state_q)
        NS_G: state_d = NS_Y;
        NS_Y: begin
          state_d   = AR1;
          nxt_dir_d = 1'b1;
        end
        AR1: begin
          if (ped_pend_q) begin
            state_d    = WALK;
            ped_pend_d = 1'b0;
          end else begin
            state_d = EW_G;
          end
        end
        EW_G: state_d = EW_Y;
        EW_Y: begin
          state_d   = AR2;
          nxt_dir_d = 1'b0;
        end
        AR2: begin
          if (ped_pend_q) begin
            state_d    = WALK;
            ped_pend_d = 1'b0;
          end else begin
            state_d = NS_G;
          end
        end
        WALK:    state_d = nxt_dir_q ? EW_G : NS_G;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    repro    = arm_q | (state_q == EMG);
    st_timer = !arm_q && (state_q != EMG);
    phase    = state_q;
    walk     = 1'b0;
    ns_light = LAMP_R;
    ew_light = LAMP_R;
    time_val = 4'd0;
    case (state_q)
      NS_G: begin
        ns_light = LAMP_G;
        time_val = T_GREEN;
      end
      NS_Y: begin
        ns_light = LAMP_Y;
        time_val = T_YELLOW;
      end
      EW_G: begin
        ew_light = LAMP_G;
        time_val = T_GREEN;
      end
      EW_Y: begin
        ew_light = LAMP_Y;
        time_val = T_YELLOW;
      end
      AR1, AR2: time_val = T_ALLRED;
      WALK: begin
        walk     = 1'b1;
        time_val = T_WALK;
      end
      default: time_val = 4'd0;
    endcase
  end

endmodule
